// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle between the two writeback sources, the load-issue
// notification and the register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              wb0_valid;
   logic              wb0_ready;
   logic [4:0]        wb0_addr;
   logic [DATA_W-1:0] wb0_data;

   logic              wb1_valid;
   logic              wb1_ready;
   logic [4:0]        wb1_addr;
   logic [DATA_W-1:0] wb1_data;

   logic              iss_valid;
   logic [4:0]        iss_addr;

   modport master (
      output wb0_valid, wb0_addr, wb0_data,
      output wb1_valid, wb1_addr, wb1_data,
      output iss_valid, iss_addr,
      input  wb0_ready, wb1_ready
   );

   modport slave (
      input  wb0_valid, wb0_addr, wb0_data,
      input  wb1_valid, wb1_addr, wb1_data,
      input  iss_valid, iss_addr,
      output wb0_ready, wb1_ready
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, load returns get a
// starvation guard, the write port is registered, and a scoreboard tracks pending loads.
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   regfile_wb_arbiter_if.slave wb,
   output logic                RegWrite,
   output logic [4:0]          WriteRegAddr,
   output logic [DATA_W-1:0]   WriteData,
   output logic [31:0]         pending
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef struct packed {
      logic              we;
      logic [4:0]        addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic [3:0]  starve_cnt;
   logic        forced;
   logic        ready0;
   logic        ready1;
   logic        xfer0;
   logic        xfer1;
   wr_t         wr_q;
   wr_t         wr_d;
   logic [31:0] pend_q;
   logic [31:0] pend_d;

   assign forced = (starve_cnt == LIMIT);

   // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      ready0 = 1'b1;
      ready1 = !wb.wb0_valid;
      if (forced) begin
         ready1 = 1'b1;
         ready0 = !wb.wb1_valid;
      end
   end

   assign wb.wb0_ready = ready0;
   assign wb.wb1_ready = ready1;
   assign xfer0        = wb.wb0_valid && ready0;
   assign xfer1        = wb.wb1_valid && ready1;

   // Counts consecutive cycles a valid load return was refused.
   // NOTE: state registers use <= so every flop samples pre-edge values; combinational logic uses =.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!wb.wb1_valid || xfer1) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Writes to x0 complete the handshake but never raise the write enable.
   always_comb begin
      wr_d    = wr_q;
      wr_d.we = 1'b0;
      if (xfer1) begin
         wr_d = '{we: (wb.wb1_addr != 5'd0), addr: wb.wb1_addr, data: wb.wb1_data};
      end else if (xfer0) begin
         wr_d = '{we: (wb.wb0_addr != 5'd0), addr: wb.wb0_addr, data: wb.wb0_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q <= '0;
      end else begin
         wr_q <= wr_d;
      end
   end

   // Clear is applied before set, so a reissue to the returning register stays pending.
   always_comb begin
      pend_d = pend_q;
      if (xfer1) begin
         pend_d[wb.wb1_addr] = 1'b0;
      end
      if (wb.iss_valid) begin
         pend_d[wb.iss_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // NOTE: the scoreboard is a flop array, not a RAM, and must clear on reset or stale bits stall readers forever.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign RegWrite     = wr_q.we;
   assign WriteRegAddr = wr_q.addr;
   assign WriteData    = wr_q.data;
   assign pending      = pend_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset sequences and a
// randomized run against a rule-level reference model.
module tb_regfile_wb_arbiter;
   localparam int DATA_W = 32;
   localparam int LIMIT  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              RegWrite;
   logic [4:0]        WriteRegAddr;
   logic [DATA_W-1:0] WriteData;
   logic [31:0]       pending;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W)) bus ();

   regfile_wb_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb           (bus),
      .RegWrite     (RegWrite),
      .WriteRegAddr (WriteRegAddr),
      .WriteData    (WriteData),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit        v0;
      bit [4:0]  a0;
      bit [31:0] d0;
      bit        v1;
      bit [4:0]  a1;
      bit [31:0] d1;
      bit        iv;
      bit [4:0]  ia;
      bit        r0;
      bit        r1;
      bit        we;
      bit [4:0]  addr;
      bit [31:0] data;
      bit [31:0] pend;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic iv, input logic [4:0] ia);
      bus.wb0_valid = v0;
      bus.wb0_addr  = a0;
      bus.wb0_data  = d0;
      bus.wb1_valid = v1;
      bus.wb1_addr  = a1;
      bus.wb1_data  = d1;
      bus.iss_valid = iv;
      bus.iss_addr  = ia;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   function automatic void add(bit v0, bit [4:0] a0, bit [31:0] d0,
                               bit v1, bit [4:0] a1, bit [31:0] d1,
                               bit iv, bit [4:0] ia, bit r0, bit r1,
                               bit we, bit [4:0] addr, bit [31:0] data, bit [31:0] pend);
      vec_t v;
      v = '{v0: v0, a0: a0, d0: d0, v1: v1, a1: a1, d1: d1, iv: iv, ia: ia,
            r0: r0, r1: r1, we: we, addr: addr, data: data, pend: pend};
      vecs.push_back(v);
   endfunction

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Reference model state: expected write-port register, scoreboard, and the
   // number of consecutive cycles a valid load return has been refused.
   bit        m_we;
   bit [4:0]  m_addr;
   bit [31:0] m_data;
   bit [31:0] m_pend;
   int        m_losses;

   initial begin
      idle();
      reset = 1'b0;

      // Reset state, asserted before any clock edge.
      #2;
      check("rst RegWrite", RegWrite, 0);
      check("rst WriteRegAddr", WriteRegAddr, 0);
      check("rst WriteData", WriteData, 0);
      check("rst pending", pending, 0);
      check("rst wb0_ready", bus.wb0_ready, 1);
      check("rst wb1_ready", bus.wb1_ready, 1);

      // Traffic offered while reset is held must be ignored.
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
      tick();
      check("inrst RegWrite", RegWrite, 0);
      check("inrst pending", pending, 0);
      idle();
      reset = 1'b1;
      tick();

      // Directed table; each row runs one cycle from the state the previous row left.
      add(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  0, 5'd0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0);
      add(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 1, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0);
      add(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd7, 1, 1, 0, 5'd5, 32'hDEADBEEF, 32'h80);
      add(0, 5'd0, 32'h0,        1, 5'd7, 32'h1234, 0, 5'd0, 1, 1, 1, 5'd7, 32'h1234, 32'h0);
      add(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd9, 1, 1, 0, 5'd7, 32'h1234, 32'h200);
      add(0, 5'd0, 32'h0,        1, 5'd9, 32'h99, 1, 5'd9, 1, 1, 1, 5'd9, 32'h99, 32'h200);
      add(1, 5'd0, 32'hAAAA,     0, 5'd0, 32'h0,  0, 5'd0, 1, 0, 0, 5'd0, 32'hAAAA, 32'h200);
      add(0, 5'd0, 32'h0,        1, 5'd0, 32'h5555, 1, 5'd0, 1, 1, 0, 5'd0, 32'h5555, 32'h200);
      add(0, 5'd0, 32'h0,        1, 5'd3, 32'h33, 0, 5'd0, 1, 1, 1, 5'd3, 32'h33, 32'h200);
      add(0, 5'd0, 32'h0,        1, 5'd9, 32'h9,  0, 5'd0, 1, 1, 1, 5'd9, 32'h9, 32'h0);
      for (int k = 0; k < 4; k++)
         add(1, 5'd1, 32'h10 + k, 1, 5'd2, 32'h20, 0, 5'd0, 1, 0, 1, 5'd1, 32'h10 + k, 32'h0);
      add(1, 5'd1, 32'h14,       1, 5'd2, 32'h20, 0, 5'd0, 0, 1, 1, 5'd2, 32'h20, 32'h0);
      add(1, 5'd1, 32'h15,       1, 5'd2, 32'h21, 0, 5'd0, 1, 0, 1, 5'd1, 32'h15, 32'h0);
      add(0, 5'd0, 32'h0,        1, 5'd2, 32'h21, 0, 5'd0, 1, 1, 1, 5'd2, 32'h21, 32'h0);
      add(1, 5'd1, 32'h17,       1, 5'd2, 32'h22, 0, 5'd0, 1, 0, 1, 5'd1, 32'h17, 32'h0);
      add(1, 5'd1, 32'h18,       0, 5'd0, 32'h0,  0, 5'd0, 1, 0, 1, 5'd1, 32'h18, 32'h0);
      for (int k = 0; k < 4; k++)
         add(1, 5'd1, 32'h19 + k, 1, 5'd2, 32'h22, 0, 5'd0, 1, 0, 1, 5'd1, 32'h19 + k, 32'h0);
      add(1, 5'd1, 32'h1D,       1, 5'd2, 32'h22, 0, 5'd0, 0, 1, 1, 5'd2, 32'h22, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1,
               vecs[i].iv, vecs[i].ia);
         #1;
         check($sformatf("v%0d wb0_ready", i), bus.wb0_ready, vecs[i].r0);
         check($sformatf("v%0d wb1_ready", i), bus.wb1_ready, vecs[i].r1);
         tick();
         check($sformatf("v%0d RegWrite", i), RegWrite, vecs[i].we);
         check($sformatf("v%0d WriteRegAddr", i), WriteRegAddr, vecs[i].addr);
         check($sformatf("v%0d WriteData", i), WriteData, vecs[i].data);
         check($sformatf("v%0d pending", i), pending, vecs[i].pend);
      end

      // Reset asserted between edges while a write is being driven.
      do_reset();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
      tick();
      check("mid pending set", pending, 32'h480);
      drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick();
      check("mid RegWrite pre", RegWrite, 1);
      check("mid pending pre", pending, 32'h480);
      idle();
      #2;
      reset = 1'b0;
      #1;
      check("mid RegWrite async", RegWrite, 0);
      check("mid pending async", pending, 0);
      check("mid WriteRegAddr async", WriteRegAddr, 0);
      check("mid WriteData async", WriteData, 0);
      tick();
      reset = 1'b1;
      tick();
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick();
      check("post RegWrite", RegWrite, 1);
      check("post WriteRegAddr", WriteRegAddr, 5);
      check("post WriteData", WriteData, 32'hDEADBEEF);
      idle();
      tick();
      check("post RegWrite drop", RegWrite, 0);

      // Randomized traffic against the reference model.
      do_reset();
      m_we = 0; m_addr = 0; m_data = 0; m_pend = 0; m_losses = 0;
      for (int c = 0; c < 400; c++) begin
         bit        v0, v1, iv, r0, r1, force1, x0, x1;
         bit [4:0]  a0, a1, ia;
         bit [31:0] d0, d1;
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 1) != 0);
         iv = ($urandom_range(0, 2) == 0);
         a0 = 5'($urandom_range(0, 31));
         a1 = 5'($urandom_range(0, 7));
         ia = 5'($urandom_range(0, 7));
         d0 = $urandom;
         d1 = $urandom;
         drive(v0, a0, d0, v1, a1, d1, iv, ia);
         #1;
         // Port 1 takes priority once it has been refused LIMIT times in a row.
         force1 = (m_losses >= LIMIT);
         r1 = force1 || !v0;
         r0 = !(force1 && v1);
         check($sformatf("r%0d wb0_ready", c), bus.wb0_ready, r0);
         check($sformatf("r%0d wb1_ready", c), bus.wb1_ready, r1);
         tick();
         x0 = v0 && r0;
         x1 = v1 && r1;
         if (x1) begin
            m_we = (a1 != 0); m_addr = a1; m_data = d1;
         end else if (x0) begin
            m_we = (a0 != 0); m_addr = a0; m_data = d0;
         end else begin
            m_we = 0;
         end
         m_losses = (v1 && !x1) ? m_losses + 1 : 0;
         if (x1) m_pend[a1] = 1'b0;
         if (iv && ia != 0) m_pend[ia] = 1'b1;
         check($sformatf("r%0d RegWrite", c), RegWrite, m_we);
         check($sformatf("r%0d WriteRegAddr", c), WriteRegAddr, m_addr);
         check($sformatf("r%0d WriteData", c), WriteData, m_data);
         check($sformatf("r%0d pending", c), pending, m_pend);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
